// File: rtl/eth_idma_reg_driver.sv
// eth_idma_reg_driver
//   Drives one eth_idma transfer over a simple register bus: writes the
//   source/destination/length/protocol registers, pulses REQ_VALID, polls
//   RSP_VALID, pulses RSP_READY, and then reports completion.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    transfer command handshake (ready only in IDLE)
//   cmd_*_i                command fields, captured on acceptance
//   done_valid_o/ready_i   completion handshake; done_error_o = status
//   busy_o                 high whenever not IDLE
//   reg_req_o / reg_rsp_i  register bus initiator request / response

package eth_idma_reg_driver_pkg;
  typedef struct packed {
    logic [7:0]  addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module eth_idma_reg_driver #(
  parameter int unsigned             DataWidth    = 32,
  parameter int unsigned             RegAddrWidth = 8,
  parameter logic [RegAddrWidth-1:0] SrcAddrOff   = 'h00,
  parameter logic [RegAddrWidth-1:0] DstAddrOff   = 'h04,
  parameter logic [RegAddrWidth-1:0] LengthOff    = 'h08,
  parameter logic [RegAddrWidth-1:0] SrcProtoOff  = 'h0C,
  parameter logic [RegAddrWidth-1:0] DstProtoOff  = 'h10,
  parameter logic [RegAddrWidth-1:0] ReqValidOff  = 'h14,
  parameter logic [RegAddrWidth-1:0] RspReadyOff  = 'h18,
  parameter logic [RegAddrWidth-1:0] RspValidOff  = 'h1C,
  parameter int unsigned             PollTimeout  = 1024,
  parameter type reg_req_t = eth_idma_reg_driver_pkg::reg_req_t,
  parameter type reg_rsp_t = eth_idma_reg_driver_pkg::reg_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DataWidth-1:0] cmd_src_addr_i,
  input  logic [DataWidth-1:0] cmd_dst_addr_i,
  input  logic [DataWidth-1:0] cmd_length_i,
  input  logic [2:0]           cmd_src_proto_i,
  input  logic [2:0]           cmd_dst_proto_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic                 done_error_o,
  output logic                 busy_o,
  output reg_req_t             reg_req_o,
  input  reg_rsp_t             reg_rsp_i
);

  localparam int unsigned           CntWidth = $clog2(PollTimeout + 1);
  localparam logic [CntWidth-1:0]   CntLast  = CntWidth'(PollTimeout - 1);

  typedef enum logic [3:0] {
    IDLE, WR_SRC, WR_DST, WR_LEN, WR_SPROTO, WR_DPROTO,
    SET_REQV, CLR_REQV, POLL, SET_RSPR, CLR_RSPR, DONE
  } state_e;

  state_e                  state_q, state_d, succ;
  logic [DataWidth-1:0]    src_q, dst_q, len_q;
  logic [2:0]              sproto_q, dproto_q;
  logic [CntWidth-1:0]     poll_cnt_q;
  logic                    err_q;

  logic                    access, is_read;
  logic                    poll_clr, poll_inc, err_set, err_clr;
  logic [RegAddrWidth-1:0] acc_addr;
  logic [DataWidth-1:0]    acc_wdata;

  // Only rdata[0] (RSP_VALID) matters to the poll loop.
  logic unused_rdata;
  assign unused_rdata = ^reg_rsp_i.rdata;

  assign done_error_o = err_q;
  assign busy_o       = (state_q != IDLE);

  // Each access state only selects address/data/successor; the handshake,
  // error abort and poll decisions are shared below so every access obeys
  // the same hold-until-ready rule.
  always_comb begin
    state_d      = state_q;
    reg_req_o    = '0;
    acc_addr     = '0;
    acc_wdata    = '0;
    access       = 1'b1;
    is_read      = 1'b0;
    succ         = IDLE;
    poll_clr     = 1'b0;
    poll_inc     = 1'b0;
    err_set      = 1'b0;
    err_clr      = 1'b0;
    cmd_ready_o  = 1'b0;
    done_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        access      = 1'b0;
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = WR_SRC;
      end
      WR_SRC:    begin acc_addr = SrcAddrOff;  acc_wdata = src_q;               succ = WR_DST;    end
      WR_DST:    begin acc_addr = DstAddrOff;  acc_wdata = dst_q;               succ = WR_LEN;    end
      WR_LEN:    begin acc_addr = LengthOff;   acc_wdata = len_q;               succ = WR_SPROTO; end
      WR_SPROTO: begin acc_addr = SrcProtoOff; acc_wdata = DataWidth'(sproto_q); succ = WR_DPROTO; end
      WR_DPROTO: begin acc_addr = DstProtoOff; acc_wdata = DataWidth'(dproto_q); succ = SET_REQV;  end
      SET_REQV:  begin acc_addr = ReqValidOff; acc_wdata = DataWidth'(1);       succ = CLR_REQV;  end
      CLR_REQV:  begin acc_addr = ReqValidOff;                                  succ = POLL;      end
      POLL:      begin acc_addr = RspValidOff; is_read = 1'b1;                  succ = SET_RSPR;  end
      SET_RSPR:  begin acc_addr = RspReadyOff; acc_wdata = DataWidth'(1);       succ = CLR_RSPR;  end
      CLR_RSPR:  begin acc_addr = RspReadyOff;                                  succ = DONE;      end
      DONE: begin
        access       = 1'b0;
        done_valid_o = 1'b1;
        if (done_ready_i) begin
          state_d = IDLE;
          err_clr = 1'b1;
        end
      end
      default: begin
        access  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (access) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.write = !is_read;
      reg_req_o.addr  = acc_addr;
      reg_req_o.wdata = acc_wdata;
      if (!is_read) reg_req_o.wstrb = '1;
      if (reg_rsp_i.ready) begin
        if (reg_rsp_i.error) begin
          err_set = 1'b1;
          state_d = DONE;
        end else if (is_read && !reg_rsp_i.rdata[0]) begin
          if (poll_cnt_q == CntLast) begin
            err_set = 1'b1;
            state_d = DONE;
          end else begin
            poll_inc = 1'b1;
          end
        end else begin
          state_d  = succ;
          poll_clr = (succ == POLL);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      sproto_q   <= '0;
      dproto_q   <= '0;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid_i) begin
        src_q    <= cmd_src_addr_i;
        dst_q    <= cmd_dst_addr_i;
        len_q    <= cmd_length_i;
        sproto_q <= cmd_src_proto_i;
        dproto_q <= cmd_dst_proto_i;
      end
      if (poll_clr)      poll_cnt_q <= '0;
      else if (poll_inc) poll_cnt_q <= poll_cnt_q + CntWidth'(1);
      if (err_set)       err_q <= 1'b1;
      else if (err_clr)  err_q <= 1'b0;
    end
  end

endmodule
